// File: rtl/id_ex_pipe.sv
// id_ex_pipe: decode-to-execute pipeline register with a one-entry skid buffer and a saturating stall counter
// Ports:
//   clk, rst (sync, active-low)   clock and reset
//   flush                         drop held entries and the beat offered this cycle
//   in_valid/in_ready + in_*      upstream beat (in_ready is registered: !skid_valid)
//   out_valid/out_ready + out_*   registered payload to execute; empty slots are zero bubbles
//   stall_cnt                     cycles with out_valid && !out_ready, saturating
module id_ex_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_inst_type,
    input  logic [7:0]            in_inst_opcode,
    input  logic [DATA_WIDTH-1:0] in_op1,
    input  logic [DATA_WIDTH-1:0] in_op2,
    input  logic [4:0]            in_rd_addr,
    input  logic                  in_rd_w_ena,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_inst_type,
    output logic [7:0]            out_inst_opcode,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [4:0]            out_rd_addr,
    output logic                  out_rd_w_ena,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    localparam int PW = 19 + 2 * DATA_WIDTH;

    logic [PW-1:0]        w_in_pl;
    logic [PW-1:0]        r_out_pl;
    logic [PW-1:0]        r_skid_pl;
    logic                 r_out_valid;
    logic                 r_skid_valid;
    logic                 w_accept;
    logic                 w_load;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    assign w_in_pl  = {in_inst_type, in_inst_opcode, in_op1, in_op2, in_rd_addr, in_rd_w_ena};
    assign in_ready = rst && !r_skid_valid;
    assign w_accept = in_valid && in_ready && !flush;
    // output slot is free to change when empty or being drained this cycle
    assign w_load   = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_pl     <= '0;
            r_skid_pl    <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_out_valid && !out_ready && r_stall_cnt != {CNT_WIDTH{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
                r_out_pl     <= '0;
                r_skid_pl    <= '0;
            end else if (w_load) begin
                // skid entry is older than anything on the input, so it goes first
                r_out_valid  <= r_skid_valid || w_accept;
                r_out_pl     <= r_skid_valid ? r_skid_pl : (w_accept ? w_in_pl : '0);
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_pl    <= w_in_pl;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign stall_cnt = r_stall_cnt;
    assign {out_inst_type, out_inst_opcode, out_op1, out_op2, out_rd_addr, out_rd_w_ena} = r_out_pl;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: scoreboard bench for id_ex_pipe against a queue-based occupancy model
module tb_id_ex_pipe;
    typedef logic [146:0] pl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  in_inst_type = '0;
    logic [7:0]  in_inst_opcode = '0;
    logic [63:0] in_op1 = '0;
    logic [63:0] in_op2 = '0;
    logic [4:0]  in_rd_addr = '0;
    logic        in_rd_w_ena = 1'b0;

    logic        in_ready, out_valid, out_rd_w_ena;
    logic [4:0]  out_inst_type, out_rd_addr;
    logic [7:0]  out_inst_opcode;
    logic [63:0] out_op1, out_op2;
    logic [31:0] stall_cnt;

    logic        in_ready4, out_valid4, out_rd_w_ena4;
    logic [4:0]  out_inst_type4, out_rd_addr4;
    logic [7:0]  out_inst_opcode4;
    logic [63:0] out_op14, out_op24;
    logic [3:0]  stall4;

    pl_t         dut_pl;
    pl_t         q[$];
    int          held = 0;
    logic [31:0] m_cnt = '0;
    logic [3:0]  m_c4 = '0;
    bit          acc;
    bit          mon_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst_type(in_inst_type), .in_inst_opcode(in_inst_opcode), .in_op1(in_op1),
        .in_op2(in_op2), .in_rd_addr(in_rd_addr), .in_rd_w_ena(in_rd_w_ena),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst_type(out_inst_type),
        .out_inst_opcode(out_inst_opcode), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd_addr(out_rd_addr), .out_rd_w_ena(out_rd_w_ena), .stall_cnt(stall_cnt)
    );

    id_ex_pipe #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_inst_type(in_inst_type), .in_inst_opcode(in_inst_opcode), .in_op1(in_op1),
        .in_op2(in_op2), .in_rd_addr(in_rd_addr), .in_rd_w_ena(in_rd_w_ena),
        .out_valid(out_valid4), .out_ready(out_ready), .out_inst_type(out_inst_type4),
        .out_inst_opcode(out_inst_opcode4), .out_op1(out_op14), .out_op2(out_op24),
        .out_rd_addr(out_rd_addr4), .out_rd_w_ena(out_rd_w_ena4), .stall_cnt(stall4)
    );

    assign dut_pl = {out_inst_type, out_inst_opcode, out_op1, out_op2, out_rd_addr, out_rd_w_ena};

    task automatic chk(input string n, input pl_t act, input pl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    // reference model: the block holds up to two beats in arrival order
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            q.delete();
            held = 0;
            m_cnt = '0;
            m_c4 = '0;
            mon_en = 1'b1;
        end else begin
            if (held > 0 && !out_ready) begin
                if (m_cnt != 32'hffff_ffff) m_cnt++;
                if (m_c4 != 4'hf) m_c4++;
            end
            acc = in_valid && held < 2 && !flush;
            if (flush) begin
                q.delete();
                held = 0;
            end else begin
                if (held > 0 && out_ready) held--;
                if (acc) begin
                    held++;
                    q.push_back({in_inst_type, in_inst_opcode, in_op1, in_op2, in_rd_addr, in_rd_w_ena});
                end
            end
        end
    end

    // monitor: compare presented outputs, retire the head on a transfer
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("in_ready", pl_t'(in_ready), pl_t'(rst && held < 2));
            chk("out_valid", pl_t'(out_valid), pl_t'(held > 0));
            chk("payload", dut_pl, (held > 0 && q.size() > 0) ? q[0] : '0);
            chk("stall_cnt", pl_t'(stall_cnt), pl_t'(m_cnt));
            chk("stall_cnt4", pl_t'(stall4), pl_t'(m_c4));
            if (held > 0 && out_ready && rst && q.size() > 0) void'(q.pop_front());
        end
    end

    task automatic step(input bit v, input bit ordy, input bit fl, input logic [7:0] opc,
                        input logic [63:0] a, input logic [63:0] b);
        in_valid       = v;
        out_ready      = ordy;
        flush          = fl;
        in_inst_opcode = opc;
        in_op1         = a;
        in_op2         = b;
        in_inst_type   = 5'($urandom);
        in_rd_addr     = 5'($urandom);
        in_rd_w_ena    = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step(1, 0, 0, 8'haa, 64'd1, 64'd2);
        rst = 1'b1;
        step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        step(1, 1, 0, 8'h01, 64'd5, 64'd7);
        step(1, 1, 0, 8'h02, 64'd5, 64'd7);
        step(1, 1, 0, 8'h03, 64'd5, 64'd7);
        repeat (2) step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        step(1, 1, 0, 8'h01, 64'd11, 64'd12);
        step(1, 0, 0, 8'h02, 64'd13, 64'd14);
        repeat (3) step(1, 0, 0, 8'h09, 64'd15, 64'd16);
        repeat (3) step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        step(1, 1, 0, 8'h01, 64'd21, 64'd22);
        step(1, 0, 0, 8'h02, 64'd23, 64'd24);
        step(1, 0, 1, 8'h03, 64'd25, 64'd26);
        step(0, 0, 0, 8'h00, 64'd0, 64'd0);
        repeat (2) step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        step(1, 0, 0, 8'h04, 64'd31, 64'd32);
        repeat (20) step(0, 0, 0, 8'h00, 64'd0, 64'd0);
        repeat (2) step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        step(1, 0, 0, 8'h05, 64'd41, 64'd42);
        step(1, 0, 0, 8'h06, 64'd43, 64'd44);
        rst = 1'b0;
        step(0, 0, 0, 8'h00, 64'd0, 64'd0);
        rst = 1'b1;
        repeat (3) step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        repeat (600) begin
            rst = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0,
                 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        end
        rst = 1'b1;
        repeat (3) step(0, 1, 0, 8'h00, 64'd0, 64'd0);
        @(negedge clk);
        chk("final_queue", pl_t'(q.size()), pl_t'(held));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- Pipeline register between the decode stage and the execute stage.
- Captures decoded fields (inst_type, inst_opcode, op1, op2, destination register) and presents them to the execute stage with a valid/ready handshake.
- A one-entry skid buffer lets upstream be back-pressured with a registered in_ready. Flush drops in-flight instructions; empty slots present as opcode 0 bubbles.
- Contains a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_WIDTH, 64, operand width (matches `DATA_WIDTH`).
- CNT_WIDTH, 32, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- flush  in  1  drop all held entries and any beat offered this cycle.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat. Equals !skid_valid; forced to 0 while rst==0.
- in_inst_type  in  5  decoded instruction class.
- in_inst_opcode  in  8  decoded opcode.
- in_op1  in  DATA_WIDTH  operand 1.
- in_op2  in  DATA_WIDTH  operand 2.
- in_rd_addr  in  5  destination register index.
- in_rd_w_ena  in  1  destination write enable.
- out_valid  out  1  payload to execute stage valid.
- out_ready  in  1  execute stage accepts payload.
- out_inst_type, out_inst_opcode, out_op1, out_op2, out_rd_addr, out_rd_w_ena  out  same widths as inputs  registered payload.
- stall_cnt  out  CNT_WIDTH  cycles with out_valid && !out_ready, saturating.

Behaviour:
- State: output register (out_valid + payload); skid register (skid_valid + payload); stall_cnt.
- Reset (rst==0 at edge):
  - out_valid=0, skid_valid=0, all out_* payload=0, stall_cnt=0.
  - in_ready reads 0 while rst==0 and 1 on the first cycle after release.
- Handshakes:
  - Accept: in_valid && in_ready && !flush.
  - Drain: out_valid && out_ready.
  - Payload is stable while out_valid && !out_ready.
- Output register update, when !out_valid || out_ready:
  - If skid_valid: load skid payload, out_valid=1, skid_valid=0.
  - Else if accept: load input payload, out_valid=1.
  - Else: out_valid=0 and all out_* payload zeroed. A bubble is opcode 0, so execute produces zero.
- Skid capture: accept && out_valid && !out_ready → input payload to skid, skid_valid=1.
- Latency and throughput:
  - A beat accepted at edge N is visible on out_* after edge N (1-cycle latency) when the path is clear.
  - Full throughput of 1 beat/cycle while out_ready stays high.
- Skid drain cycle: in_ready=0 (skid occupied), so no input is accepted while skid moves to the output. No beat is ever lost or duplicated.
- Full condition: out_valid && skid_valid. in_ready=0 until the next drain.
- Flush:
  - Highest priority after reset; next edge sets out_valid=0, skid_valid=0, payload=0.
  - A beat offered with flush=1 is discarded even if in_ready=1.
  - A drain on the flush cycle still counts as transferred.
  - stall_cnt is unaffected by flush.
- stall_cnt increments by 1 each edge where out_valid && !out_ready. It saturates at all-ones (no wrap) and is cleared only by reset.
- Ordering: strict FIFO; the skid entry is always older than any later input.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, all out_* payload=0, stall_cnt=0. Release → in_ready=1 next cycle.
- Streaming: out_ready=1, send opcodes 0x01,0x02,0x03 with op1=5,op2=7 on consecutive cycles → same sequence on out_* one cycle later, out_valid high 3 consecutive cycles, stall_cnt=0.
- Back-pressure: out_ready=0 after beat A (opcode 0x01), present B (0x02) → B goes to skid, in_ready=0. Hold 4 cycles → stall_cnt=4, out_* stays A. Raise out_ready → A, then B, in order; in_ready returns 1 after B moves to output.
- Flush while full: A in output, B in skid, C offered with flush=1 → next cycle out_valid=0, in_ready=1, out_inst_opcode=0. C never appears.
- Saturation: CNT_WIDTH=4, hold out_valid with out_ready=0 for 20 cycles → stall_cnt stops at 15.
- Reset mid-operation: both entries occupied, rst=0 for one edge → out_valid=0, skid cleared, stall_cnt=0. No stale beat emerges after release.
